dot_product_mac: RTL and testbench



---
 rtl/dot_product_mac_pkg.sv | 23 ++
 rtl/mac_shift_add_mul.sv | 45 ++++
 rtl/dot_product_mac.sv | 105 ++++++++++
 tb/tb_dot_product_mac.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dot_product_mac_pkg.sv
// Shared definitions for the dot-product MAC: FSM encoding, default widths, saturation limits.
// Saturation is enabled by defining DOT_PRODUCT_MAC_SAT_EN.
package dot_product_mac_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    OUT  = 2'd3
  } state_t;

  localparam int DEF_N         = 16;
  localparam int DEF_ACC_GUARD = 4;

  function automatic int acc_width(input int n, input int guard);
    return 2*n + guard;
  endfunction

  localparam int DEF_ACC_W = acc_width(DEF_N, DEF_ACC_GUARD);

  // Clamp values for the default accumulator width
  localparam logic [DEF_ACC_W-1:0] DEF_SAT_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
  localparam logic [DEF_ACC_W-1:0] DEF_SAT_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};
endpackage

// File: rtl/mac_shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier: one multiplier bit per cycle, N cycles per product.
module mac_shift_add_mul
  import dot_product_mac_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [2*N-1:0] prod,
  output logic           done
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  a_q, b_q;
  logic [CW-1:0] cnt;
  logic          busy;

  // done flags the cycle whose edge performs the final partial-product add
  assign done = busy && (cnt == CW'(N-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      prod <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_q  <= mcand;
      b_q  <= mplier;
      prod <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (b_q[cnt])
        prod <= prod + ({{N{1'b0}}, a_q} << cnt);
      cnt <= cnt + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end
endmodule

// File: rtl/dot_product_mac.sv
// Signed dot-product MAC: sign-magnitude multiply via mac_shift_add_mul, then accumulate per vector.
// Define DOT_PRODUCT_MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module dot_product_mac
  import dot_product_mac_pkg::*;
#(
  parameter  int N         = DEF_N,
  parameter  int ACC_GUARD = DEF_ACC_GUARD,
  localparam int ACC_W     = 2*N + ACC_GUARD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);
  state_t           state;
  logic             sign, last;
  logic [ACC_W-1:0] acc, addend, sum;
  logic [N-1:0]     mag_a, mag_b;
  logic [2*N-1:0]   prod;
  logic             mul_start, mul_done, add_ovf;

  // -2^(N-1) negates to itself, which reads correctly as the unsigned magnitude
  assign mag_a     = in_a[N-1] ? -in_a : in_a;
  assign mag_b     = in_b[N-1] ? -in_b : in_b;
  assign mul_start = (state == IDLE) && in_valid && in_ready;

  assign addend  = sign ? -ACC_W'(prod) : ACC_W'(prod);
  assign sum     = acc + addend;
  assign add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

`ifdef DOT_PRODUCT_MAC_SAT_EN
  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  logic [ACC_W-1:0] acc_nxt;
  assign acc_nxt = add_ovf ? (addend[ACC_W-1] ? SAT_MIN : SAT_MAX) : sum;
`else
  logic [ACC_W-1:0] acc_nxt;
  assign acc_nxt = sum;
`endif

  mac_shift_add_mul #(.N(N)) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .mcand  (mag_a),
    .mplier (mag_b),
    .prod   (prod),
    .done   (mul_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
      acc       <= '0;
      sign      <= 1'b0;
      last      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          sign     <= in_a[N-1] ^ in_b[N-1];
          last     <= in_last;
          in_ready <= 1'b0;
          state    <= MUL;
        end
        MUL: if (mul_done) state <= ACC;
        ACC: begin
          acc <= acc_nxt;
          if (add_ovf) out_ovf <= 1'b1;
          if (last) begin
            state <= OUT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        OUT: begin
          // first OUT cycle publishes the result; it then holds until accepted
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_acc   <= acc;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_ovf   <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dot_product_mac.sv
// Randomized and directed checks of dot_product_mac against an arithmetic dot-product model.
module tb_dot_product_mac;
  localparam int N = 16;
  localparam int W = 36;
  localparam longint MAXV = (64'sd1 <<< 35) - 1;
  localparam longint MINV = -(64'sd1 <<< 35);

  logic          clk = 1'b0, rst;
  logic          in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [N-1:0]  in_a, in_b;
  logic [W-1:0]  out_acc;

  int vecs = 0, errs = 0;

  dot_product_mac dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_acc(out_acc), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Reference: exact integer sum, checked against the 36-bit signed range after every term
  function automatic void model_add(inout longint acc, inout bit ovf,
                                    input logic signed [N-1:0] a, input logic signed [N-1:0] b);
    longint p, s;
    p = longint'(a) * longint'(b);
    s = acc + p;
    if (s > MAXV || s < MINV) begin
      ovf = 1'b1;
`ifdef DOT_PRODUCT_MAC_SAT_EN
      s = (p < 0) ? MINV : MAXV;
`else
      s = (s > MAXV) ? s - (64'sd1 <<< 36) : s + (64'sd1 <<< 36);
`endif
    end
    acc = s;
  endfunction

  task automatic send_pair(input logic signed [N-1:0] a, input logic signed [N-1:0] b, input logic last);
    for (int t = 0; t < 100 && !in_ready; t++) @(negedge clk);
    if (!in_ready) begin
      errs++; $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    vecs++;
    if (in_ready !== 1'b0) begin
      errs++; $display("FAIL busy_after_accept: in_ready=%0b required 0", in_ready);
    end
  endtask

  // Counts rising edges after the accept edge until out_valid is seen
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (cyc < 200 && out_valid !== 1'b1) begin
      @(negedge clk); cyc++;
    end
    if (out_valid !== 1'b1) begin
      errs++; $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
  endtask

  task automatic check_result(input string name, input longint exp_acc, input bit exp_ovf);
    logic [W-1:0] e;
    int cyc;
    e = exp_acc[W-1:0];
    wait_result(cyc);
    vecs++;
    if (out_acc !== e || out_ovf !== exp_ovf) begin
      errs++;
      $display("FAIL %s: out_acc=%h out_ovf=%0b required out_acc=%h out_ovf=%0b", name, out_acc, out_ovf, e, exp_ovf);
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vecs++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0 || in_ready !== 1'b1) begin
      errs++;
      $display("FAIL after_handshake: valid=%0b acc=%h ovf=%0b ready=%0b required 0,0,0,1", out_valid, out_acc, out_ovf, in_ready);
    end
  endtask

  task automatic test_reset();
    vecs++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_state: ready=%0b valid=%0b acc=%h ovf=%0b required 1,0,0,0", in_ready, out_valid, out_acc, out_ovf);
    end
  endtask

  task automatic test_single();
    int cyc;
    send_pair(16'sd3, 16'sd5, 1'b1);
    wait_result(cyc);
    vecs++;
    if (cyc != N + 2) begin
      errs++; $display("FAIL latency: %0d cycles required %0d", cyc, N + 2);
    end
    check_result("single_3x5", 15, 1'b0);
    take_result();
  endtask

  task automatic test_vector();
    send_pair(-16'sd4, 16'sd7, 1'b0);
    send_pair(16'sd2, -16'sd3, 1'b0);
    send_pair(-16'sd1, -16'sd1, 1'b1);
    check_result("vector_m33", -33, 1'b0);
    take_result();
  endtask

  task automatic test_extremes();
    send_pair(-16'sd32768, -16'sd32768, 1'b1);
    check_result("min_x_min", 64'h040000000, 1'b0);
    take_result();
    send_pair(-16'sd32768, 16'sd32767, 1'b1);
    check_result("min_x_max", 64'shFFFFFFFFC0008000, 1'b0);
    take_result();
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    send_pair(16'sd9, 16'sd9, 1'b0);
    while (cyc < 100 && in_ready !== 1'b1) begin
      @(negedge clk); cyc++;
    end
    vecs++;
    if (cyc != N + 1) begin
      errs++; $display("FAIL pair_period: ready after %0d cycles required %0d", cyc, N + 1);
    end
    send_pair(16'sd1, -16'sd2, 1'b1);
    check_result("back_to_back", 79, 1'b0);
    take_result();
  endtask

  task automatic test_backpressure();
    send_pair(16'sd7, 16'sd9, 1'b1);
    check_result("bp_first", 63, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vecs++;
      if (out_valid !== 1'b1 || out_acc !== 36'd63 || in_ready !== 1'b0) begin
        errs++;
        $display("FAIL bp_hold: valid=%0b acc=%h ready=%0b required 1,03f,0", out_valid, out_acc, in_ready);
      end
    end
    take_result();
    send_pair(16'sd1, 16'sd1, 1'b1);
    check_result("bp_cleared", 1, 1'b0);
    take_result();
  endtask

  task automatic test_overflow();
    longint acc = 0;
    bit ovf = 0;
    for (int i = 0; i < 32; i++) begin
      send_pair(-16'sd32768, -16'sd32768, i == 31);
      model_add(acc, ovf, -16'sd32768, -16'sd32768);
    end
    check_result("overflow", acc, ovf);
    take_result();
  endtask

  task automatic test_reset_mid();
    send_pair(16'sd5, 16'sd5, 1'b0);
    send_pair(16'sd3, 16'sd3, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    vecs++;
    if (out_valid !== 1'b0 || out_acc !== '0 || out_ovf !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid: valid=%0b acc=%h ovf=%0b required 0,0,0", out_valid, out_acc, out_ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    vecs++;
    if (in_ready !== 1'b1) begin
      errs++; $display("FAIL reset_mid_ready: in_ready=%0b required 1", in_ready);
    end
    send_pair(16'sd2, 16'sd2, 1'b1);
    check_result("after_reset", 4, 1'b0);
    take_result();
  endtask

  task automatic test_random();
    for (int v = 0; v < 8; v++) begin
      longint acc = 0;
      bit ovf = 0;
      int len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) begin
        logic signed [N-1:0] a, b;
        a = N'($urandom);
        b = N'($urandom);
        if ($urandom_range(0, 5) == 0) a = '0;
        model_add(acc, ovf, a, b);
        send_pair(a, b, i == len - 1);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      check_result("random_vector", acc, ovf);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      take_result();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_vector();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
